// File: rtl/pq_pkg.sv
// Shared types for the priority_queue command scheduler.
// Key type, queue command bundle and default sizing.
package pq_pkg;

  localparam int PQ_DEPTH  = 30;
  localparam int KEY_W     = 10;
  localparam int RSP_DEPTH = 4;
  localparam int CNT_W     = $clog2(PQ_DEPTH) + 1;

  typedef logic [KEY_W-1:0] key_t;

  typedef struct packed {
    logic valid;
    logic write;
    key_t data;
  } cmd_t;

endpackage

// File: rtl/pq_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy output.
// A write into a full FIFO is taken only alongside a read.
module pq_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_wr;
  logic          do_rd;

  assign do_rd = rd_en && (cnt != '0);
  assign do_wr = wr_en && ((cnt != FULL) || do_rd);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr)
        wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      if (do_rd)
        rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr)
      mem[wptr] <= wr_data;
  end

  assign rd_valid = (cnt != '0);
  assign rd_data  = mem[rptr];
  assign count    = cnt;

endmodule

// File: rtl/pq_cmd_sched.sv
// Merges push and pop-request streams onto the priority_queue command
// port, tracking occupancy and reserving response FIFO space per pop.
module pq_cmd_sched
  import pq_pkg::*;
#(
  parameter int QUEUE_DEPTH    = PQ_DEPTH,
  parameter int DATA_LENGTH    = KEY_W,
  parameter int RSP_FIFO_DEPTH = RSP_DEPTH
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           s_push_valid,
  output logic                           s_push_ready,
  input  logic [DATA_LENGTH-1:0]         s_push_data,
  input  logic                           s_pop_valid,
  output logic                           s_pop_ready,
  output logic                           m_rsp_valid,
  input  logic                           m_rsp_ready,
  output logic [DATA_LENGTH-1:0]         m_rsp_data,
  output logic                           q_valid,
  output logic                           q_write,
  output logic [DATA_LENGTH-1:0]         q_data,
  input  logic                           q_o_valid,
  input  logic [DATA_LENGTH-1:0]         q_o_data,
  output logic [$clog2(QUEUE_DEPTH):0]   o_count,
  output logic                           o_err
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int RW = $clog2(RSP_FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_C  = CW'(QUEUE_DEPTH);
  localparam logic [RW:0]   RSV_MAX = (RW+1)'(RSP_FIFO_DEPTH);

  logic [CW-1:0] count;
  logic [RW-1:0] infl;
  logic [RW-1:0] fifo_cnt;
  logic [RW:0]   reserved;
  logic          pop_pri;
  logic          err;
  cmd_t          cmd_q;

  logic push_room;
  logic pop_room;
  logic push_ok;
  logic pop_ok;
  logic acc_push;
  logic acc_pop;
  logic cap;

  // Every pop holds a FIFO slot from acceptance until its key is read.
  assign reserved  = {1'b0, infl} + {1'b0, fifo_cnt};
  assign push_room = (count < FULL_C);
  assign pop_room  = (count != '0) && (reserved < RSV_MAX);
  assign push_ok   = s_push_valid && push_room;
  assign pop_ok    = s_pop_valid && pop_room;

  assign s_push_ready = push_room && !(pop_ok && pop_pri);
  assign s_pop_ready  = pop_room && !(push_ok && !pop_pri);

  assign acc_push = s_push_valid && s_push_ready;
  assign acc_pop  = s_pop_valid && s_pop_ready;
  assign cap      = q_o_valid && (infl != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count   <= '0;
      infl    <= '0;
      pop_pri <= 1'b1;
      err     <= 1'b0;
      cmd_q   <= '0;
    end else begin
      cmd_q.valid <= acc_push || acc_pop;
      cmd_q.write <= acc_push;
      cmd_q.data  <= acc_push ? s_push_data : '0;
      unique case (1'b1)
        acc_push: begin
          count   <= count + CW'(1);
          pop_pri <= 1'b1;
        end
        acc_pop: begin
          count   <= count - CW'(1);
          pop_pri <= 1'b0;
        end
        default: ;
      endcase
      case ({acc_pop, cap})
        2'b10:   infl <= infl + RW'(1);
        2'b01:   infl <= infl - RW'(1);
        default: infl <= infl;
      endcase
      if (q_o_valid && (infl == '0))
        err <= 1'b1;
    end
  end

  pq_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .W     (DATA_LENGTH)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (cap),
    .wr_data  (q_o_data),
    .rd_en    (m_rsp_ready),
    .rd_valid (m_rsp_valid),
    .rd_data  (m_rsp_data),
    .count    (fifo_cnt)
  );

  assign q_valid = cmd_q.valid;
  assign q_write = cmd_q.write;
  assign q_data  = cmd_q.data;
  assign o_count = count;
  assign o_err   = err;

endmodule

// File: tb/tb_pq_cmd_sched.sv
// Bench for pq_cmd_sched with a behavioural priority_queue attached
// and a scoreboard model of grants, occupancy and responses.
module tb_pq_cmd_sched;
  import pq_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic             s_push_valid;
  logic             s_push_ready;
  logic [KEY_W-1:0] s_push_data;
  logic             s_pop_valid;
  logic             s_pop_ready;
  logic             m_rsp_valid;
  logic             m_rsp_ready;
  logic [KEY_W-1:0] m_rsp_data;
  logic             q_valid;
  logic             q_write;
  logic [KEY_W-1:0] q_data;
  logic             q_o_valid;
  logic [KEY_W-1:0] q_o_data;
  logic [CNT_W-1:0] o_count;
  logic             o_err;

  logic             pq_ov;
  logic [KEY_W-1:0] pq_od;
  logic             force_ov;

  always #5 CLK = ~CLK;

  pq_cmd_sched dut (
    .CLK          (CLK),
    .RST          (RST),
    .s_push_valid (s_push_valid),
    .s_push_ready (s_push_ready),
    .s_push_data  (s_push_data),
    .s_pop_valid  (s_pop_valid),
    .s_pop_ready  (s_pop_ready),
    .m_rsp_valid  (m_rsp_valid),
    .m_rsp_ready  (m_rsp_ready),
    .m_rsp_data   (m_rsp_data),
    .q_valid      (q_valid),
    .q_write      (q_write),
    .q_data       (q_data),
    .q_o_valid    (q_o_valid),
    .q_o_data     (q_o_data),
    .o_count      (o_count),
    .o_err        (o_err)
  );

  assign q_o_valid = pq_ov | force_ov;
  assign q_o_data  = pq_od;

  // Behavioural priority_queue: pop result one cycle after the command.
  int pqm[$];
  always @(posedge CLK) begin : pq_model
    int k;
    if (RST) begin
      pqm.delete();
      pq_ov <= 1'b0;
      pq_od <= '0;
    end else begin
      pq_ov <= 1'b0;
      if (q_valid && q_write) begin
        k = 0;
        while (k < pqm.size() && pqm[k] <= int'(q_data)) k++;
        pqm.insert(k, int'(q_data));
      end else if (q_valid && pqm.size() > 0) begin
        pq_od <= KEY_W'(pqm[0]);
        pq_ov <= 1'b1;
        void'(pqm.pop_front());
      end
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard state
  int r_cnt;
  int r_pq[$];
  int r_key[$];
  int r_at[$];
  bit r_popw;
  bit r_err;
  bit r_qv;
  bit r_qw;
  int r_qd;
  int t = 0;

  bit s_pr, s_ppr, s_rv, s_qv, s_err;
  int s_cnt, s_rd;
  bit a_push, a_pop;

  task automatic ref_reset();
    r_cnt = 0;
    r_pq.delete();
    r_key.delete();
    r_at.delete();
    r_popw = 1'b1;
    r_err = 1'b0;
    r_qv = 1'b0;
    r_qw = 1'b0;
    r_qd = 0;
  endtask

  task automatic step(input bit pv, input int pd, input bit ppv,
                      input bit rr, input bit fo);
    bit push_room, pop_room, push_ok, pop_ok;
    bit g_push, g_pop, e_rv, infl;
    int k;
    @(negedge CLK);
    s_push_valid = pv;
    s_push_data  = KEY_W'(pd);
    s_pop_valid  = ppv;
    m_rsp_ready  = rr;
    force_ov     = fo;
    #1;
    s_pr   = s_push_ready;
    s_ppr  = s_pop_ready;
    s_rv   = m_rsp_valid;
    s_rd   = int'(m_rsp_data);
    s_cnt  = int'(o_count);
    s_qv   = q_valid;
    s_err  = o_err;
    a_push = pv && s_push_ready;
    a_pop  = ppv && s_pop_ready;
    push_room = r_cnt < PQ_DEPTH;
    pop_room  = r_cnt > 0 && r_key.size() < RSP_DEPTH;
    push_ok   = pv && push_room;
    pop_ok    = ppv && pop_room;
    g_pop     = pop_ok && (r_popw || !push_ok);
    g_push    = push_ok && !g_pop;
    chk("push_grant", a_push, g_push);
    chk("pop_grant", a_pop, g_pop);
    if (!pv && !ppv) begin
      chk("idle_push_ready", s_pr, push_room);
      chk("idle_pop_ready", s_ppr, pop_room);
    end
    chk("count", s_cnt, r_cnt);
    chk("q_valid", s_qv, r_qv);
    if (r_qv) begin
      chk("q_write", q_write, r_qw);
      if (r_qw) chk("q_data", q_data, r_qd);
    end
    chk("err", s_err, r_err);
    e_rv = r_at.size() > 0 && r_at[0] + 3 <= t;
    chk("rsp_valid", s_rv, e_rv);
    if (e_rv) begin
      chk("rsp_data", s_rd, r_key[0]);
      if (rr) begin
        void'(r_key.pop_front());
        void'(r_at.pop_front());
      end
    end
    infl = 1'b0;
    foreach (r_at[i])
      if (r_at[i] + 1 <= t && t <= r_at[i] + 2) infl = 1'b1;
    if (fo && !infl) r_err = 1'b1;
    r_qv = g_push || g_pop;
    r_qw = g_push;
    r_qd = pd;
    if (g_push) begin
      k = 0;
      while (k < r_pq.size() && r_pq[k] <= pd) k++;
      r_pq.insert(k, pd);
      r_cnt++;
      r_popw = 1'b1;
    end
    if (g_pop) begin
      r_key.push_back(r_pq[0]);
      r_at.push_back(t);
      void'(r_pq.pop_front());
      r_cnt--;
      r_popw = 1'b0;
    end
    t++;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    s_push_valid = 1'b0;
    s_pop_valid  = 1'b0;
    m_rsp_ready  = 1'b0;
    force_ov     = 1'b0;
    @(negedge CLK);
    #1;
    chk("rst_count", o_count, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_write", q_write, 0);
    chk("rst_rsp_valid", m_rsp_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_push_ready", s_push_ready, 1);
    chk("rst_pop_ready", s_pop_ready, 0);
    RST = 1'b0;
    ref_reset();
  endtask

  typedef struct {
    bit pv; int pd; bit ppv; bit rr;
    bit epr; bit eppr; int ecnt; bit erv; int erd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, np;
    int gotq[$];
    int keys[10];
    int expk[4];
    RST = 1'b1;
    s_push_valid = 1'b0;
    s_push_data  = '0;
    s_pop_valid  = 1'b0;
    m_rsp_ready  = 1'b0;
    force_ov     = 1'b0;

    // push 5,3,9 then pop x3: rsp 3,5,9, first one 3 cycles after accept
    tbl[0] = '{1, 5, 0, 1, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 3, 0, 1, 1, 1, 1, 0, 0};
    tbl[2] = '{1, 9, 0, 1, 1, 1, 2, 0, 0};
    tbl[3] = '{0, 0, 1, 1, 0, 1, 3, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 1, 1, 2, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 1, 1, 0, 0, 1, 3};
    tbl[7] = '{0, 0, 0, 1, 1, 0, 0, 1, 5};
    tbl[8] = '{0, 0, 0, 1, 1, 0, 0, 1, 9};
    tbl[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].pv, tbl[i].pd, tbl[i].ppv, tbl[i].rr, 1'b0);
      chk("tbl_push_ready", s_pr, tbl[i].epr);
      chk("tbl_pop_ready", s_ppr, tbl[i].eppr);
      chk("tbl_count", s_cnt, tbl[i].ecnt);
      chk("tbl_rsp_valid", s_rv, tbl[i].erv);
      if (tbl[i].erv) chk("tbl_rsp_data", s_rd, tbl[i].erd);
    end

    // pop on an empty queue
    do_reset();
    repeat (5) begin
      step(0, 0, 1, 1, 0);
      chk("empty_pop_ready", s_ppr, 0);
      chk("empty_q_valid", s_qv, 0);
      chk("empty_err", s_err, 0);
    end

    // fill to capacity, 31st push held until a pop frees a slot
    do_reset();
    n = 0;
    for (int i = 0; i < 40 && n < 30; i++) begin
      step(1, 100 + n, 0, 1, 0);
      if (a_push) n++;
    end
    chk("fill_accepted", n, 30);
    repeat (3) begin
      step(1, 500, 0, 1, 0);
      chk("full_push_ready", s_pr, 0);
      chk("full_count", s_cnt, 30);
    end
    step(1, 500, 1, 1, 0);
    chk("full_pop_first", a_pop, 1);
    chk("full_push_blocked", a_push, 0);
    step(1, 500, 0, 1, 0);
    chk("held_push_taken", a_push, 1);
    for (int i = 0; i < 120 && (r_cnt != 0 || r_key.size() != 0); i++)
      step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("drain_count", s_cnt, 0);
    chk("drain_rsp_valid", s_rv, 0);

    // both streams valid from count=2: pop,push,pop,...
    do_reset();
    step(1, 40, 0, 1, 0);
    step(1, 41, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 200 + i, 1, 1, 0);
      chk("alt_pop", a_pop, (i % 2 == 0) ? 1 : 0);
      chk("alt_push", a_push, (i % 2 == 0) ? 0 : 1);
      chk("alt_count", s_cnt, (i % 2 == 0) ? 2 : 1);
    end

    // response back-pressure limits pops to the FIFO depth
    do_reset();
    keys = '{50, 20, 70, 10, 90, 30, 80, 40, 60, 15};
    expk = '{10, 15, 20, 30};
    foreach (keys[i]) step(1, keys[i], 0, 0, 0);
    np = 0;
    repeat (6) begin
      step(0, 0, 1, 0, 0);
      if (a_pop) np++;
    end
    chk("bp_pops", np, 4);
    chk("bp_pop_ready", s_ppr, 0);
    chk("bp_count", s_cnt, 6);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 0);
      if (s_rv) gotq.push_back(s_rd);
    end
    chk("bp_rsp_n", gotq.size(), 4);
    for (int i = 0; i < 4 && i < gotq.size(); i++)
      chk("bp_rsp_order", gotq[i], expk[i]);

    // spurious q_o_valid, then reset mid-burst
    do_reset();
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("err_set", s_err, 1);
    step(1, 7, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("err_sticky", s_err, 1);
    step(1, 11, 0, 1, 0);
    step(1, 12, 0, 1, 0);
    step(1, 13, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    do_reset();
    repeat (4) begin
      step(0, 0, 0, 1, 0);
      chk("mid_rst_rsp_valid", s_rv, 0);
      chk("mid_rst_count", s_cnt, 0);
    end

    // random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, 1023)),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 70, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
